// File: rtl/uart_pkg.sv
// Shared constants and types for the UART frame parser:
// SYNC byte, FSM state encoding and err_code values.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hAA;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: MAX_LEN x 8 register array, one synchronous write port,
// one combinational read port. Data is deliberately not reset.
module uart_frame_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_LEN];

    // Capture one payload byte per accepted rx byte
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: SYNC(AA), LEN, LEN payload bytes [, CSUM].
// Verified payloads are replayed on a valid/ready byte stream.
// Optional checksum stage is compiled in with `define UART_FRAME_CSUM_EN.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int MAX_LEN      = 16,
    parameter int TIMEOUT_CLKS = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_finish,
    input  logic [7:0] rx_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_CLKS);

    state_t        state;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [CW-1:0] idle_cnt;
`ifdef UART_FRAME_CSUM_EN
    logic [7:0]    csum;
`endif

    logic          in_frame;
    logic          timeout_hit;
    logic          buf_we;
    logic [AW-1:0] buf_waddr;
    logic [AW-1:0] buf_raddr;
    logic [7:0]    buf_rdata;

    assign in_frame    = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    assign timeout_hit = in_frame && (idle_cnt == TIMEOUT_C);

    // Same index drives both ports: writes in PAYLOAD, reads in DRAIN.
    // While a byte is already presented, read ahead so the next byte is
    // ready the cycle the current one is accepted.
    assign buf_we    = (state == ST_PAYLOAD) && rx_finish && !timeout_hit;
    assign buf_waddr = idx[AW-1:0];
    assign buf_raddr = out_valid ? buf_waddr + AW'(1) : buf_waddr;

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (buf_we),
        .wr_addr (buf_waddr),
        .wr_data (rx_data),
        .rd_addr (buf_raddr),
        .rd_data (buf_rdata)
    );

    // Inter-byte idle counter, only live while a frame is being received
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            idle_cnt <= '0;
        else if (!in_frame || timeout_hit || rx_finish)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + CW'(1);
    end

    // Frame FSM with registered outputs; timeout takes priority over any byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            len       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= ERR_NONE;
            overrun   <= 1'b0;
`ifdef UART_FRAME_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (timeout_hit) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                state     <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rx_finish && rx_data == SYNC_BYTE)
                            state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if (rx_finish) begin
                            if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_LEN;
                                state     <= ST_IDLE;
                            end else begin
                                len   <= rx_data;
                                idx   <= '0;
`ifdef UART_FRAME_CSUM_EN
                                csum  <= rx_data;
`endif
                                state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        // SYNC values here are ordinary data
                        if (rx_finish) begin
`ifdef UART_FRAME_CSUM_EN
                            csum <= csum ^ rx_data;
`endif
                            if (idx == len - 8'd1) begin
                                idx   <= '0;
`ifdef UART_FRAME_CSUM_EN
                                state <= ST_CSUM;
`else
                                state <= ST_DRAIN;
`endif
                            end else begin
                                idx <= idx + 8'd1;
                            end
                        end
                    end
                    ST_CSUM: begin
`ifdef UART_FRAME_CSUM_EN
                        if (rx_finish) begin
                            if (rx_data == csum) begin
                                state <= ST_DRAIN;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= ERR_CSUM;
                                state     <= ST_IDLE;
                            end
                        end
`else
                        state <= ST_IDLE;
`endif
                    end
                    ST_DRAIN: begin
                        // Bytes arriving now cannot be stored; flag and drop
                        if (rx_finish)
                            overrun <= 1'b1;
                        if (!out_valid) begin
                            out_valid <= 1'b1;
                            out_data  <= buf_rdata;
                            out_last  <= (len == 8'd1);
                        end else if (out_ready) begin
                            if (out_last) begin
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                                idx       <= '0;
                                state     <= ST_IDLE;
                            end else begin
                                idx      <= idx + 8'd1;
                                out_data <= buf_rdata;
                                out_last <= (idx + 8'd2 == len);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: the driver queues expected beats
// and errors, a negedge monitor pops and compares them as the DUT emits.
module tb_uart_frame_parser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_finish = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       out_ready = 1'b1;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;
    logic [1:0] err_code;
    logic       overrun;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .MAX_LEN      (16),
        .TIMEOUT_CLKS (5000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_finish (rx_finish),
        .rx_data   (rx_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .err_code  (err_code),
        .overrun   (overrun)
    );

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         last;
        logic [1:0] code;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    bit   stall = 1'b0;
    logic [8:0] stall_beat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: output stability under backpressure, beats and error pulses
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_beat", 32'({out_last, out_data}), 32'(stall_beat));
            end
            stall      = out_valid && !out_ready;
            stall_beat = {out_last, out_data};
            if (overrun) ovr_seen++;
            if (out_valid && out_ready) begin
                if (q.size() == 0 || q[0].is_err) begin
                    checks++; errors++;
                    $display("FAIL beat_unexpected: got data %0h last %0b, expected none", out_data, out_last);
                    if (q.size() != 0) void'(q.pop_front());
                end else begin
                    e = q.pop_front();
                    check("beat_data", 32'(out_data), 32'(e.data));
                    check("beat_last", 32'(out_last), 32'(e.last));
                end
            end
            if (frame_err) begin
                if (q.size() == 0 || !q[0].is_err) begin
                    checks++; errors++;
                    $display("FAIL err_unexpected: got err_code %0d, expected no error", err_code);
                    if (q.size() != 0) void'(q.pop_front());
                end else begin
                    e = q.pop_front();
                    check("err_code", 32'(err_code), 32'(e.code));
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data   = b;
        rx_finish = 1'b1;
        @(posedge clk); #1;
        rx_finish = 1'b0;
    endtask

    task automatic send_csum(input logic [7:0] b);
`ifdef UART_FRAME_CSUM_EN
        send(b);
`else
        if (b === 8'hxx) send(b);
`endif
    endtask

    task automatic push_beat(input logic [7:0] d, input bit last);
        exp_t e;
        e.is_err = 1'b0; e.data = d; e.last = last; e.code = 2'd0;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.data = 8'h00; e.last = 1'b0; e.code = code;
        q.push_back(e);
    endtask

    task automatic wait_empty(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        check(name, 32'(q.size()), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},   32'(out_valid), 32'd0);
        check({tag, "_data"},    32'(out_data),  32'd0);
        check({tag, "_last"},    32'(out_last),  32'd0);
        check({tag, "_ferr"},    32'(frame_err), 32'd0);
        check({tag, "_errcode"}, 32'(err_code),  32'd0);
        check({tag, "_overrun"}, 32'(overrun),   32'd0);
    endtask

    initial begin
        #12;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        cycles(2);

        // Basic frame, checksum 03^11^22^33 = 03
        push_beat(8'h11, 0); push_beat(8'h22, 0); push_beat(8'h33, 1);
        send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send_csum(8'h03);
        wait_empty("frame_basic", 50);

`ifdef UART_FRAME_CSUM_EN
        // Checksum should be 02^55^66 = 31; 00 is rejected
        push_err(2'd2);
        send(8'hAA); send(8'h02); send(8'h55); send(8'h66); send(8'h00);
        wait_empty("csum_bad", 50);
`endif

        // Zero length and over-long length, then a good single-byte frame
        push_err(2'd1);
        send(8'hAA); send(8'h00);
        wait_empty("len_zero", 20);
        push_err(2'd1);
        send(8'hAA); send(8'h11);
        wait_empty("len_big", 20);
        cycles(3);
        check("err_code_held", 32'(err_code), 32'd1);
        push_beat(8'h5A, 1);
        send(8'hAA); send(8'h01); send(8'h5A); send_csum(8'h5B);
        wait_empty("len_one", 50);

        // Noise before SYNC, SYNC value inside payload; csum 02^AA^07 = AF
        push_beat(8'hAA, 0); push_beat(8'h07, 1);
        send(8'h12); send(8'h34);
        send(8'hAA); send(8'h02); send(8'hAA); send(8'h07); send_csum(8'hAF);
        wait_empty("sync_as_data", 50);

        // Stall mid-payload until the idle timeout fires
        push_err(2'd3);
        send(8'hAA); send(8'h04); send(8'h01); send(8'h02);
        cycles(4990);
        check("tmo_not_early", 32'(q.size()), 32'd1);
        wait_empty("tmo_fired", 40);
        check("tmo_code_held", 32'(err_code), 32'd3);

        // Backpressure with an injected byte; csum 03^A1^B2^C3 = D3
        out_ready = 1'b0;
        push_beat(8'hA1, 0); push_beat(8'hB2, 0); push_beat(8'hC3, 1);
        send(8'hAA); send(8'h03); send(8'hA1); send(8'hB2); send(8'hC3); send_csum(8'hD3);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            cycles(1);
        end
        check("bp_valid_seen", 32'(out_valid), 32'd1);
        cycles(4);
        ovr_exp++;
        send(8'hEE);
        cycles(14);
        check("bp_no_accept", 32'(q.size()), 32'd3);
        out_ready = 1'b1;
        wait_empty("bp_drain", 50);

        // Reset mid-payload abandons the frame silently
        send(8'hAA); send(8'h05); send(8'h01); send(8'h02);
        rst_n = 1'b0;
        #3;
        check_idle_outputs("midrst");
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        // csum 02^C0^DE = 1C
        push_beat(8'hC0, 0); push_beat(8'hDE, 1);
        send(8'hAA); send(8'h02); send(8'hC0); send(8'hDE); send_csum(8'h1C);
        wait_empty("post_reset", 50);

        cycles(5);
        check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
        check("final_queue", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum payload bytes per frame (range 1..255).
REQ-002 Parameter TIMEOUT_CLKS, default 5000, SHALL set the inter-byte idle limit in clock cycles while a frame is in progress.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_finish  input  1  one-cycle pulse; rx_data holds a valid received byte.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 out_valid  output  1  out_data holds a payload byte of a verified frame.
REQ-008 out_data  output  8  payload byte, in arrival order.
REQ-009 out_last  output  1  high with the final payload byte of the frame.
REQ-010 out_ready  input  1  consumer accepts the byte when out_valid and out_ready are both high.
REQ-011 frame_err  output  1  one-cycle pulse on a rejected frame.
REQ-012 err_code  output  2  1 = bad length, 2 = checksum mismatch, 3 = timeout; held until the next frame_err.
REQ-013 overrun  output  1  one-cycle pulse when a byte arrives during DRAIN and is discarded.

Function
REQ-014 Frame format SHALL be: SYNC (8'hAA), LEN, LEN payload bytes, then CSUM (CSUM only when the checksum feature is enabled).
REQ-015 FSM states SHALL be IDLE, LEN, PAYLOAD, CSUM, DRAIN.
REQ-016 IDLE: a byte equal to 8'hAA SHALL move to LEN; any other byte SHALL be ignored silently.
REQ-017 LEN: LEN = 0 or LEN > MAX_LEN SHALL pulse frame_err, set err_code = 1 and return to IDLE; otherwise the FSM SHALL store LEN, clear the byte index and go to PAYLOAD.
REQ-018 PAYLOAD: each byte SHALL be written to buffer[index] and the index incremented; after byte LEN the FSM SHALL go to CSUM, or to DRAIN if the checksum feature is disabled.
REQ-019 The running checksum SHALL be the 8-bit XOR of LEN and all payload bytes; SYNC is excluded.
REQ-020 CSUM: a byte equal to the running XOR SHALL move to DRAIN; a mismatch SHALL pulse frame_err, set err_code = 2 and return to IDLE.
REQ-021 DRAIN: buffer[0..LEN-1] SHALL be presented on out_data with out_valid high; each index advances only on handshake; out_last SHALL be high for index LEN-1.
REQ-022 Handshake on the last byte SHALL return the FSM to IDLE with out_valid low on the next cycle.
REQ-023 out_data and out_valid SHALL be stable while out_valid is high and out_ready is low.
REQ-024 The first out_valid SHALL assert on the cycle after the state register enters DRAIN.
REQ-025 An rx_finish during DRAIN SHALL pulse overrun, discard the byte and leave the buffer unchanged.
REQ-026 In LEN, PAYLOAD or CSUM, the idle counter SHALL clear on every rx_finish and increment otherwise.
REQ-027 When the idle counter reaches TIMEOUT_CLKS, the block SHALL pulse frame_err, set err_code = 3 and return to IDLE.
REQ-028 A byte arriving on the same cycle the timeout fires SHALL be discarded.
REQ-029 A SYNC value received inside LEN or PAYLOAD SHALL be treated as data, not as a resynchronisation.

Reset
REQ-030 Reset low SHALL force: state IDLE, out_valid 0, out_last 0, out_data 0, frame_err 0, err_code 0, overrun 0, index 0, idle counter 0, checksum 0.
REQ-031 Reset asserted mid-frame or mid-DRAIN SHALL abandon the frame without emitting frame_err; buffer contents need not be cleared.

Configuration
REQ-032 Macro UART_FRAME_CSUM_EN defined: the CSUM state and check SHALL be compiled in, and err_code 2 is reachable.
REQ-033 UART_FRAME_CSUM_EN undefined: PAYLOAD SHALL go directly to DRAIN, no checksum logic SHALL be synthesised, and err_code 2 SHALL never occur.

Structure
REQ-034 Shared package uart_pkg SHALL hold the SYNC byte constant, the FSM state typedef and the err_code constants.
REQ-035 The payload store SHALL be sub-module uart_frame_buf: MAX_LEN x 8 register array with one write port and one read port, no reset on data.

Verification
REQ-036 With CSUM_EN: AA 03 11 22 33 CSUM=03 -> out_data 11, 22, 33 with out_last on 33 and no frame_err.
REQ-037 With CSUM_EN: AA 02 55 66 CSUM=00 -> frame_err pulse, err_code 2, no out_valid.
REQ-038 AA 00, and separately AA 11 with MAX_LEN 16 -> frame_err, err_code 1; a following valid frame is accepted.
REQ-039 AA 04 01 02, then 5000 idle cycles -> frame_err, err_code 3; state IDLE.
REQ-040 Valid frame with out_ready held low for 20 cycles, plus a byte injected during DRAIN -> out_data stable, overrun pulse, payload intact.
REQ-041 Reset pulled low mid-PAYLOAD -> all outputs 0; the next frame parses correctly.
